// File: rtl/ysyx_22050019_pkg.sv
// Shared types for the ysyx_22050019 bus fabric: FSM encodings, master ids, AXI resp codes.
package ysyx_22050019_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AR_IFU = 3'd1,
    AR_LSU = 3'd2,
    R_IFU  = 3'd3,
    R_LSU  = 3'd4
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } mst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22050019_rr_arb2.sv
// Two-way round-robin pick: req[0]=IFU, req[1]=LSU; on a tie the master not served last wins.
module ysyx_22050019_rr_arb2
  import ysyx_22050019_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == MST_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22050019_axi_arbiter.sv
// Merges IFU (read-only) and LSU (read/write) AXI masters onto one memory slave.
// Reads are round-robin arbitrated single-beat; the LSU write path is an independent pass-through.
module ysyx_22050019_axi_arbiter
  import ysyx_22050019_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read master
  input  logic                ifu_ar_valid,
  output logic                ifu_ar_ready,
  input  logic [ADDR_W-1:0]   ifu_ar_addr,
  output logic                ifu_r_valid,
  input  logic                ifu_r_ready,
  output logic [DATA_W-1:0]   ifu_r_data,
  output logic [1:0]          ifu_r_resp,
  // LSU read master
  input  logic                lsu_ar_valid,
  output logic                lsu_ar_ready,
  input  logic [ADDR_W-1:0]   lsu_ar_addr,
  output logic                lsu_r_valid,
  input  logic                lsu_r_ready,
  output logic [DATA_W-1:0]   lsu_r_data,
  output logic [1:0]          lsu_r_resp,
  // LSU write master
  input  logic                lsu_aw_valid,
  output logic                lsu_aw_ready,
  input  logic [ADDR_W-1:0]   lsu_aw_addr,
  input  logic                lsu_w_valid,
  output logic                lsu_w_ready,
  input  logic [DATA_W-1:0]   lsu_w_data,
  input  logic [DATA_W/8-1:0] lsu_w_strb,
  output logic                lsu_b_valid,
  input  logic                lsu_b_ready,
  output logic [1:0]          lsu_b_resp,
  // memory slave
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  output logic [ADDR_W-1:0]   s_ar_addr,
  input  logic                s_r_valid,
  output logic                s_r_ready,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic [1:0]          s_r_resp,
  output logic                s_aw_valid,
  input  logic                s_aw_ready,
  output logic [ADDR_W-1:0]   s_aw_addr,
  output logic                s_w_valid,
  input  logic                s_w_ready,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_b_valid,
  output logic                s_b_ready,
  input  logic [1:0]          s_b_resp,
  output logic                rd_err
);

  rd_state_t  rd_state, rd_next;
  wr_state_t  wr_state, wr_next;
  mst_t       last_gnt;
  logic [1:0] gnt;

  ysyx_22050019_rr_arb2 u_rr (
    .req  ({lsu_ar_valid, ifu_ar_valid}),
    .last (last_gnt),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= IDLE;
      wr_state <= W_IDLE;
      last_gnt <= MST_IFU;
      rd_err   <= 1'b0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_state == R_IFU && s_r_valid && s_r_ready) last_gnt <= MST_IFU;
      if (rd_state == R_LSU && s_r_valid && s_r_ready) last_gnt <= MST_LSU;
      if ((s_r_valid && s_r_ready && s_r_resp != RESP_OKAY) ||
          (s_b_valid && s_b_ready && s_b_resp != RESP_OKAY))
        rd_err <= 1'b1;
    end
  end

  // Read path; outputs are held quiet while rst is high.
  always_comb begin
    rd_next      = rd_state;
    s_ar_valid   = 1'b0;
    s_ar_addr    = '0;
    s_r_ready    = 1'b0;
    ifu_ar_ready = 1'b0;
    ifu_r_valid  = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = 2'b00;
    lsu_ar_ready = 1'b0;
    lsu_r_valid  = 1'b0;
    lsu_r_data   = '0;
    lsu_r_resp   = 2'b00;
    if (!rst) begin
      case (rd_state)
        IDLE: begin
          if (gnt[0]) begin
            s_ar_valid   = ifu_ar_valid;
            s_ar_addr    = ifu_ar_addr;
            ifu_ar_ready = s_ar_ready;
            rd_next      = s_ar_ready ? R_IFU : AR_IFU;
          end else if (gnt[1]) begin
            s_ar_valid   = lsu_ar_valid;
            s_ar_addr    = lsu_ar_addr;
            lsu_ar_ready = s_ar_ready;
            rd_next      = s_ar_ready ? R_LSU : AR_LSU;
          end
        end
        AR_IFU: begin
          s_ar_valid   = ifu_ar_valid;
          s_ar_addr    = ifu_ar_addr;
          ifu_ar_ready = s_ar_ready;
          if (ifu_ar_valid && s_ar_ready) rd_next = R_IFU;
        end
        AR_LSU: begin
          s_ar_valid   = lsu_ar_valid;
          s_ar_addr    = lsu_ar_addr;
          lsu_ar_ready = s_ar_ready;
          if (lsu_ar_valid && s_ar_ready) rd_next = R_LSU;
        end
        R_IFU: begin
          ifu_r_valid = s_r_valid;
          ifu_r_data  = s_r_data;
          ifu_r_resp  = s_r_resp;
          s_r_ready   = ifu_r_ready;
          if (s_r_valid && ifu_r_ready) rd_next = IDLE;
        end
        R_LSU: begin
          lsu_r_valid = s_r_valid;
          lsu_r_data  = s_r_data;
          lsu_r_resp  = s_r_resp;
          s_r_ready   = lsu_r_ready;
          if (s_r_valid && lsu_r_ready) rd_next = IDLE;
        end
        default: rd_next = IDLE;
      endcase
    end
  end

  // In W_IDLE, W travels only alongside AW so a combined beat moves straight to W_RESP;
  // the memory is expected not to take W ahead of its address.
  always_comb begin
    wr_next      = wr_state;
    s_aw_valid   = 1'b0;
    s_aw_addr    = '0;
    s_w_valid    = 1'b0;
    s_w_data     = '0;
    s_w_strb     = '0;
    s_b_ready    = 1'b0;
    lsu_aw_ready = 1'b0;
    lsu_w_ready  = 1'b0;
    lsu_b_valid  = 1'b0;
    lsu_b_resp   = 2'b00;
    if (!rst) begin
      case (wr_state)
        W_IDLE: begin
          s_aw_valid   = lsu_aw_valid;
          s_aw_addr    = lsu_aw_addr;
          lsu_aw_ready = s_aw_ready;
          s_w_valid    = lsu_w_valid && lsu_aw_valid;
          s_w_data     = lsu_w_data;
          s_w_strb     = lsu_w_strb;
          lsu_w_ready  = s_w_ready && s_aw_ready;
          if (lsu_aw_valid && s_aw_ready)
            wr_next = (lsu_w_valid && s_w_ready) ? W_RESP : W_DATA;
        end
        W_DATA: begin
          s_w_valid   = lsu_w_valid;
          s_w_data    = lsu_w_data;
          s_w_strb    = lsu_w_strb;
          lsu_w_ready = s_w_ready;
          if (lsu_w_valid && s_w_ready) wr_next = W_RESP;
        end
        W_RESP: begin
          lsu_b_valid = s_b_valid;
          lsu_b_resp  = s_b_resp;
          s_b_ready   = lsu_b_ready;
          if (s_b_valid && lsu_b_ready) wr_next = W_IDLE;
        end
        default: wr_next = W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
// Directed bench for the AXI arbiter; read data expectations flow through a scoreboard queue.
module tb_ysyx_22050019_axi_arbiter;
  import ysyx_22050019_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
  logic [ADDR_W-1:0] ifu_ar_addr;
  logic [DATA_W-1:0] ifu_r_data;
  logic [1:0]        ifu_r_resp;
  logic              lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
  logic [ADDR_W-1:0] lsu_ar_addr;
  logic [DATA_W-1:0] lsu_r_data;
  logic [1:0]        lsu_r_resp;
  logic              lsu_aw_valid, lsu_aw_ready, lsu_w_valid, lsu_w_ready;
  logic              lsu_b_valid, lsu_b_ready;
  logic [ADDR_W-1:0] lsu_aw_addr;
  logic [DATA_W-1:0] lsu_w_data;
  logic [7:0]        lsu_w_strb;
  logic [1:0]        lsu_b_resp;
  logic              s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [ADDR_W-1:0] s_ar_addr;
  logic [DATA_W-1:0] s_r_data;
  logic [1:0]        s_r_resp;
  logic              s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [ADDR_W-1:0] s_aw_addr;
  logic [DATA_W-1:0] s_w_data;
  logic [7:0]        s_w_strb;
  logic [1:0]        s_b_resp;
  logic              rd_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_data[$];
  logic              exp_who[$];

  always #5 clk = ~clk;

  ysyx_22050019_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
    .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp),
    .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
    .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp),
    .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
    .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb),
    .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .rd_err(rd_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present one read beat on the slave R channel and record what the master must see.
  task automatic drive_r(input logic who, input logic [63:0] data, input logic [1:0] resp);
    s_r_valid = 1'b1;
    s_r_data  = data;
    s_r_resp  = resp;
    exp_data.push_back(data);
    exp_who.push_back(who);
  endtask

  task automatic sb_pop(input string tag);
    logic [63:0] d;
    logic        w;
    if (exp_data.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      d = exp_data.pop_front();
      w = exp_who.pop_front();
      if (w == MST_IFU) begin
        chk({tag, "_ifu_r_valid"}, ifu_r_valid, 1'b1);
        chk({tag, "_ifu_r_data"}, ifu_r_data, d);
        chk({tag, "_lsu_r_valid"}, lsu_r_valid, 1'b0);
        chk({tag, "_lsu_r_data"}, lsu_r_data, 64'd0);
      end else begin
        chk({tag, "_lsu_r_valid"}, lsu_r_valid, 1'b1);
        chk({tag, "_lsu_r_data"}, lsu_r_data, d);
        chk({tag, "_ifu_r_valid"}, ifu_r_valid, 1'b0);
        chk({tag, "_ifu_r_data"}, ifu_r_data, 64'd0);
      end
      chk({tag, "_s_r_ready"}, s_r_ready, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    {ifu_ar_valid, ifu_r_ready, lsu_ar_valid, lsu_r_ready} = '0;
    {lsu_aw_valid, lsu_w_valid, lsu_b_ready} = '0;
    {s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid} = '0;
    ifu_ar_addr = '0; lsu_ar_addr = '0; lsu_aw_addr = '0;
    lsu_w_data = '0; lsu_w_strb = '0; s_r_data = '0; s_r_resp = '0; s_b_resp = '0;

    // Reset: requests present while rst is high must not leak out.
    lsu_ar_valid = 1'b1; s_ar_ready = 1'b1; lsu_aw_valid = 1'b1; s_b_valid = 1'b1;
    next_cycle(); next_cycle(); settle();
    chk("rst_s_ar_valid", s_ar_valid, 1'b0);
    chk("rst_lsu_ar_ready", lsu_ar_ready, 1'b0);
    chk("rst_s_aw_valid", s_aw_valid, 1'b0);
    chk("rst_lsu_b_valid", lsu_b_valid, 1'b0);
    chk("rst_rd_state", dut.rd_state, IDLE);
    chk("rst_wr_state", dut.wr_state, W_IDLE);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_last_gnt", dut.last_gnt, MST_IFU);
    lsu_ar_valid = 1'b0; s_ar_ready = 1'b0; lsu_aw_valid = 1'b0; s_b_valid = 1'b0;
    rst = 1'b0;
    next_cycle();

    // Single LSU read with same-cycle AR handshake.
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_0010; s_ar_ready = 1'b1;
    settle();
    chk("t1_s_ar_valid", s_ar_valid, 1'b1);
    chk("t1_s_ar_addr", s_ar_addr, 32'h8000_0010);
    chk("t1_lsu_ar_ready", lsu_ar_ready, 1'b1);
    chk("t1_ifu_ar_ready", ifu_ar_ready, 1'b0);
    next_cycle();
    lsu_ar_valid = 1'b0; s_ar_ready = 1'b0; lsu_r_ready = 1'b1;
    chk("t1_state_r_lsu", dut.rd_state, R_LSU);
    drive_r(MST_LSU, 64'h1122334455667788, RESP_OKAY);
    settle();
    sb_pop("t1");
    next_cycle();
    s_r_valid = 1'b0; lsu_r_ready = 1'b0;
    chk("t1_back_idle", dut.rd_state, IDLE);
    chk("t1_last_gnt", dut.last_gnt, MST_LSU);

    // Tie after reset: LSU first, IFU one cycle after the LSU R handshake.
    rst = 1'b1; next_cycle(); rst = 1'b0;
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0100;
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_0200;
    settle();
    chk("t2_tie_addr", s_ar_addr, 32'h8000_0200);
    next_cycle();
    chk("t2_state_ar_lsu", dut.rd_state, AR_LSU);
    s_ar_ready = 1'b1;
    settle();
    chk("t2_lsu_ar_ready", lsu_ar_ready, 1'b1);
    chk("t2_ifu_ar_ready", ifu_ar_ready, 1'b0);
    next_cycle();
    lsu_ar_valid = 1'b0; s_ar_ready = 1'b0; lsu_r_ready = 1'b1;
    drive_r(MST_LSU, 64'hA5A5_0000_0000_0001, RESP_OKAY);
    settle();
    chk("t2_ifu_ar_ready_in_r", ifu_ar_ready, 1'b0);
    sb_pop("t2a");
    next_cycle();
    s_r_valid = 1'b0; lsu_r_ready = 1'b0;
    settle();
    chk("t2_ifu_granted_valid", s_ar_valid, 1'b1);
    chk("t2_ifu_granted_addr", s_ar_addr, 32'h8000_0100);
    s_ar_ready = 1'b1;
    settle();
    chk("t2_ifu_ar_ready", ifu_ar_ready, 1'b1);
    next_cycle();
    ifu_ar_valid = 1'b0; s_ar_ready = 1'b0; ifu_r_ready = 1'b1;
    drive_r(MST_IFU, 64'hA5A5_0000_0000_0002, RESP_OKAY);
    settle();
    sb_pop("t2b");
    next_cycle();
    s_r_valid = 1'b0; ifu_r_ready = 1'b0;

    // Grant lock: IFU holds the grant through a stalled AR while LSU arrives.
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0300;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_0400; end
      if (i == 3) s_ar_ready = 1'b1;
      settle();
      chk($sformatf("t3_lock_addr_%0d", i), s_ar_addr, 32'h8000_0300);
      chk($sformatf("t3_lock_lsu_rdy_%0d", i), lsu_ar_ready, 1'b0);
      next_cycle();
    end
    ifu_ar_valid = 1'b0; s_ar_ready = 1'b0; ifu_r_ready = 1'b1;
    drive_r(MST_IFU, 64'hC0DE_0000_0000_0003, RESP_OKAY);
    settle();
    sb_pop("t3a");
    next_cycle();
    s_r_valid = 1'b0; ifu_r_ready = 1'b0; s_ar_ready = 1'b1;
    settle();
    chk("t3_lsu_after_addr", s_ar_addr, 32'h8000_0400);
    chk("t3_lsu_after_rdy", lsu_ar_ready, 1'b1);
    next_cycle();
    lsu_ar_valid = 1'b0; s_ar_ready = 1'b0; lsu_r_ready = 1'b1;
    drive_r(MST_LSU, 64'hC0DE_0000_0000_0004, RESP_OKAY);
    settle();
    sb_pop("t3b");
    next_cycle();
    s_r_valid = 1'b0; lsu_r_ready = 1'b0;

    // Combined AW/W write with SLVERR response.
    lsu_aw_valid = 1'b1; lsu_aw_addr = 32'h8000_1000;
    lsu_w_valid = 1'b1; lsu_w_data = 64'hDEAD_BEEF_0BAD_F00D; lsu_w_strb = 8'h0F;
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    settle();
    chk("t4_s_aw_addr", s_aw_addr, 32'h8000_1000);
    chk("t4_s_w_valid", s_w_valid, 1'b1);
    chk("t4_s_w_strb", s_w_strb, 8'h0F);
    chk("t4_lsu_w_ready", lsu_w_ready, 1'b1);
    next_cycle();
    lsu_aw_valid = 1'b0; lsu_w_valid = 1'b0; s_aw_ready = 1'b0; s_w_ready = 1'b0;
    chk("t4_state_w_resp", dut.wr_state, W_RESP);
    s_b_valid = 1'b1; s_b_resp = RESP_SLVERR; lsu_b_ready = 1'b1;
    settle();
    chk("t4_lsu_b_valid", lsu_b_valid, 1'b1);
    chk("t4_lsu_b_resp", lsu_b_resp, RESP_SLVERR);
    chk("t4_rd_err_before", rd_err, 1'b0);
    next_cycle();
    s_b_valid = 1'b0; s_b_resp = RESP_OKAY; lsu_b_ready = 1'b0;
    chk("t4_rd_err_set", rd_err, 1'b1);
    chk("t4_state_w_idle", dut.wr_state, W_IDLE);
    next_cycle();
    chk("t4_rd_err_sticky", rd_err, 1'b1);

    // Concurrent IFU read (R_IFU) and LSU write (W_DATA).
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0500; s_ar_ready = 1'b1;
    lsu_aw_valid = 1'b1; lsu_aw_addr = 32'h8000_2000; s_aw_ready = 1'b1;
    next_cycle();
    ifu_ar_valid = 1'b0; s_ar_ready = 1'b0; lsu_aw_valid = 1'b0; s_aw_ready = 1'b0;
    chk("t5_state_r_ifu", dut.rd_state, R_IFU);
    chk("t5_state_w_data", dut.wr_state, W_DATA);
    ifu_r_ready = 1'b1;
    drive_r(MST_IFU, 64'h0F0F_0F0F_1234_5678, RESP_OKAY);
    lsu_w_valid = 1'b1; lsu_w_data = 64'h5555_AAAA_5555_AAAA; lsu_w_strb = 8'hFF; s_w_ready = 1'b1;
    settle();
    sb_pop("t5");
    chk("t5_s_w_data", s_w_data, 64'h5555_AAAA_5555_AAAA);
    chk("t5_lsu_w_ready", lsu_w_ready, 1'b1);
    next_cycle();
    s_r_valid = 1'b0; ifu_r_ready = 1'b0; lsu_w_valid = 1'b0; s_w_ready = 1'b0;
    chk("t5_rd_idle", dut.rd_state, IDLE);
    chk("t5_wr_resp", dut.wr_state, W_RESP);
    s_b_valid = 1'b1; s_b_resp = RESP_OKAY; lsu_b_ready = 1'b1;
    next_cycle();
    s_b_valid = 1'b0; lsu_b_ready = 1'b0;
    chk("t5_wr_idle", dut.wr_state, W_IDLE);

    // Reset in the middle of an LSU read and a pending write.
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_0600; s_ar_ready = 1'b1;
    lsu_aw_valid = 1'b1; lsu_aw_addr = 32'h8000_3000; s_aw_ready = 1'b1;
    next_cycle();
    s_ar_ready = 1'b0; s_aw_ready = 1'b0; lsu_aw_valid = 1'b0;
    chk("t6_state_r_lsu", dut.rd_state, R_LSU);
    s_r_valid = 1'b1; lsu_r_ready = 1'b1;
    rst = 1'b1;
    next_cycle();
    chk("t6_rd_idle", dut.rd_state, IDLE);
    chk("t6_wr_idle", dut.wr_state, W_IDLE);
    chk("t6_rd_err", rd_err, 1'b0);
    chk("t6_s_ar_valid", s_ar_valid, 1'b0);
    chk("t6_lsu_r_valid", lsu_r_valid, 1'b0);
    chk("t6_s_aw_valid", s_aw_valid, 1'b0);
    rst = 1'b0; s_r_valid = 1'b0; lsu_r_ready = 1'b0; lsu_ar_valid = 1'b0;
    next_cycle();

    chk("sb_drained", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_axi_arbiter.md
YSYX_22050019_AXI_ARBITER -- requirements
Module: ysyx_22050019_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 64, data width of all R/W channels; strobe width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports ifu_ar_valid/ifu_ar_ready (in/out, 1), ifu_ar_addr (in, ADDR_W), ifu_r_valid (out, 1), ifu_r_ready (in, 1), ifu_r_data (out, DATA_W) and ifu_r_resp (out, 2), forming the IFU read-only master port.
REQ-006 SHALL have ports lsu_ar_valid/ready, lsu_ar_addr, lsu_r_valid/ready/data/resp with the same directions and widths as REQ-005, forming the LSU read master port.
REQ-007 SHALL have ports lsu_aw_valid/ready, lsu_aw_addr (ADDR_W), lsu_w_valid/ready, lsu_w_data (DATA_W), lsu_w_strb (DATA_W/8), and lsu_b_valid/ready/resp (resp 2 bits), forming the LSU write master port.
REQ-008 SHALL have a slave-side port s_* that mirrors REQ-006 and REQ-007 with directions reversed and connects to the memory.
REQ-009 SHALL have port rd_err, output, 1: sticky flag, set when any R or B response is non-zero.

Function
REQ-010 SHALL implement the read-arbiter FSM states IDLE, AR_IFU, AR_LSU, R_IFU and R_LSU.
REQ-011 In IDLE, when exactly one master asserts ar_valid, that master SHALL win.
REQ-012 In IDLE, when both masters assert ar_valid, the master not served last SHALL win; last_gnt resets to IFU, so LSU wins the first tie.
REQ-013 In IDLE, the winner's ar_valid/ar_addr SHALL drive s_ar in the same cycle, and s_ar_ready SHALL return only to the winner.
REQ-014 From IDLE, an AR handshake SHALL move the FSM to R_<winner>; otherwise it SHALL move to AR_<winner>, locking the grant.
REQ-015 In AR_x, s_ar SHALL be driven only by master x, and the FSM SHALL go to R_x on s_ar handshake; a newly arriving request from the other master SHALL NOT steal the grant.
REQ-016 In R_x, s_r_valid/data/resp SHALL route to master x, x_r_ready SHALL route to s_r_ready, and the other master SHALL see r_valid=0 and ar_ready=0.
REQ-017 The R_x handshake SHALL be single-beat and SHALL return the FSM to IDLE with last_gnt=x on the next edge; a new grant SHALL become possible in that IDLE cycle, so the minimum arbitration bubble is 1 cycle.
REQ-018 All non-granted ar_ready/r_valid outputs SHALL be 0, and all data outputs of non-granted ports SHALL be 0.
REQ-019 The write path SHALL be LSU-only and tracked by the FSM W_IDLE, W_DATA, W_RESP.
REQ-020 In W_IDLE, aw SHALL pass through; an aw handshake SHALL go to W_DATA, and a simultaneous aw and w handshake SHALL go directly to W_RESP.
REQ-021 In W_DATA, w SHALL pass through, and a w handshake SHALL go to W_RESP.
REQ-022 In W_RESP, b SHALL pass through, and a b handshake SHALL go to W_IDLE.
REQ-023 Outside the write phase that is current, lsu_aw_ready, lsu_w_ready and lsu_b_valid SHALL be 0, and s_aw_valid, s_w_valid and s_b_ready SHALL be 0.
REQ-024 Read and write FSMs SHALL be independent, and concurrent read and write SHALL be allowed.
REQ-025 rd_err SHALL set on an R or B handshake with resp != 2'b00, and SHALL clear only on reset.
REQ-026 There SHALL be no combinational path from s_*_ready to s_*_valid.

Reset
REQ-027 When rst=1 at a clock edge, the read FSM SHALL go to IDLE, the write FSM SHALL go to W_IDLE, last_gnt SHALL go to IFU and rd_err SHALL go to 0.
REQ-028 While in reset state, all valid and ready outputs SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction without emitting a response; the slave is reset by the same rst.

Structure
REQ-030 FSM state encodings and the AXI resp constants (OKAY=2'b00, SLVERR=2'b10) SHALL reside in the shared ysyx_22050019 package.
REQ-031 The round-robin winner selection SHALL be a single sub-module, ysyx_22050019_rr_arb2, with inputs req[1:0] and last, and output gnt[1:0].
REQ-032 The write pass-through SHALL stay inline.

Verification
REQ-033 Reset then single LSU read: lsu_ar_valid=1 with addr 0x8000_0010 and s_ar_ready=1 in the same cycle -> s_ar_addr=0x8000_0010 that cycle; s_r_data=0x1122334455667788 is returned on lsu_r_data; ifu_r_valid stays 0.
REQ-034 Tie: both masters assert ar_valid in IDLE after reset -> LSU is granted first; after its R handshake, IFU is granted 1 cycle later.
REQ-035 Grant lock: IFU request with s_ar_ready held 0 for 3 cycles while LSU asserts in cycle 2 -> s_ar_addr stays at the IFU address for all 4 cycles; LSU is served after IFU's R.
REQ-036 Write with combined AW/W: aw_valid=w_valid=1 with strb 0x0F and both readies 1 -> W_RESP on the next cycle; b_resp=2'b10 -> lsu_b_resp=2'b10 and rd_err=1 thereafter.
REQ-037 Concurrency: an LSU write in W_DATA while an IFU read is in R_IFU -> both complete with correct routing and no stall of either.
REQ-038 Reset mid-op: rst=1 in R_LSU -> the next cycle shows IDLE/W_IDLE, all valids 0 and rd_err 0.
